spi_reg_slave: RTL and testbench

SPI mode-0 slave giving an external SPI master byte-wide register access over 24-bit frames: opcode, address, data. The SPI pins are oversampled in the single system clock domain, so there is no logic clocked by sclk. Status inputs td0/td1 are read-only, and a bank of scratch registers is read/write. The block sits between the board SPI header and fabric status/debug signals.

---
 rtl/spi_reg_pkg.sv | 21 ++
 rtl/spi_reg_slave_if.sv | 10 +
 rtl/spi_sync_edge.sv | 29 ++
 rtl/spi_reg_slave.sv | 143 ++++++++++++++
 tb/tb_spi_reg_slave.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/spi_reg_pkg.sv
// Shared constants and state type for the SPI register slave.
package spi_reg_pkg;

  localparam logic [7:0] OP_WRITE  = 8'h40;
  localparam logic [7:0] OP_READ   = 8'h41;
  localparam logic [7:0] ADDR_ID   = 8'h00;
  localparam logic [7:0] ADDR_TD0  = 8'h01;
  localparam logic [7:0] ADDR_TD1  = 8'h02;
  localparam logic [7:0] ADDR_FCNT = 8'h7F;
  localparam logic [7:0] ID_VALUE  = 8'hA5;
  localparam int unsigned FRAME_BITS = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_DONE
  } state_t;

endpackage

// File: rtl/spi_reg_slave_if.sv
// SPI pin bundle between an external master and the register slave.
interface spi_reg_slave_if;
  logic sclk_i;
  logic csn_i;
  logic mosi_i;
  logic miso_o;

  modport slave  (input  sclk_i, csn_i, mosi_i, output miso_o);
  modport master (output sclk_i, csn_i, mosi_i, input  miso_o);
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser with rise/fall detection on the synchronised level.
module spi_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      chain <= {STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  assign rise = chain[STAGES-1] & ~prev;
  assign fall = ~chain[STAGES-1] & prev;

endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 register slave, oversampled in the clk domain; 24-bit opcode/address/data frames.
// Optional frame counter at 0x7F enabled by defining SPI_FRAME_CNT_EN.
module spi_reg_slave
  import spi_reg_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [7:0]      td0,
  input  logic [7:0]      td1,
  spi_reg_slave_if.slave  spi
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);

  logic sclk_rise, sclk_fall, csn_rise, csn_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic mosi_s;

  state_t     state;
  logic [4:0] cnt;
  logic [7:0] op_r, addr_r, data_r, tx_sr, rd_byte;
  logic       load_rd, wr_pend, miso_r, last_rise;
  logic [7:0] regs [NUM_REGS];

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rstn(rstn), .d(spi.sclk_i), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_csn (
    .clk(clk), .rstn(rstn), .d(spi.csn_i), .rise(csn_rise), .fall(csn_fall)
  );

  // Same depth as the sclk chain so mosi lines up with the detected rising edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) mosi_sync <= '0;
    else       mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.mosi_i};
  end
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign last_rise = (state == ST_DATA) && sclk_rise && !csn_rise &&
                     (cnt == 5'(FRAME_BITS - 1));

`ifdef SPI_FRAME_CNT_EN
  logic [7:0] fcnt;
  logic       op_valid;
  assign op_valid = (op_r == OP_READ) || (op_r == OP_WRITE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                      fcnt <= '0;
    else if (last_rise && op_valid) fcnt <= fcnt + 8'd1;
  end
`endif

  always_comb begin
    rd_byte = '0;
    if (addr_r[7]) begin
      rd_byte = regs[addr_r[IDX_W-1:0]];
    end else begin
      case (addr_r)
        ADDR_ID:   rd_byte = ID_VALUE;
        ADDR_TD0:  rd_byte = td0;
        ADDR_TD1:  rd_byte = td1;
`ifdef SPI_FRAME_CNT_EN
        ADDR_FCNT: rd_byte = fcnt;
`endif
        default:   rd_byte = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      op_r    <= '0;
      addr_r  <= '0;
      data_r  <= '0;
      tx_sr   <= '0;
      load_rd <= 1'b0;
      wr_pend <= 1'b0;
      miso_r  <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      // The write commits outside the state case so a quick csn release cannot lose it.
      if (wr_pend) regs[addr_r[IDX_W-1:0]] <= data_r;
      wr_pend <= 1'b0;
      load_rd <= 1'b0;
      if (csn_rise) begin
        state  <= ST_IDLE;
        cnt    <= '0;
        miso_r <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: if (csn_fall) begin
            state  <= ST_CMD;
            cnt    <= '0;
            miso_r <= 1'b0;
          end
          ST_CMD: if (sclk_rise) begin
            op_r <= {op_r[6:0], mosi_s};
            cnt  <= cnt + 5'd1;
            if (cnt == 5'd7) state <= ST_ADDR;
          end
          ST_ADDR: if (sclk_rise) begin
            addr_r <= {addr_r[6:0], mosi_s};
            cnt    <= cnt + 5'd1;
            if (cnt == 5'd15) begin
              state   <= ST_DATA;
              load_rd <= 1'b1;
            end
          end
          ST_DATA: begin
            // Bit 7 must survive the falling edge right after the 16th rise, so shifting starts after the 17th.
            if (load_rd && op_r == OP_READ) begin
              miso_r <= rd_byte[7];
              tx_sr  <= {rd_byte[6:0], 1'b0};
            end else if (sclk_fall && cnt > 5'd16) begin
              miso_r <= tx_sr[7];
              tx_sr  <= {tx_sr[6:0], 1'b0};
            end
            if (sclk_rise) begin
              data_r <= {data_r[6:0], mosi_s};
              cnt    <= cnt + 5'd1;
              if (last_rise) begin
                state   <= ST_DONE;
                miso_r  <= 1'b0;
                wr_pend <= (op_r == OP_WRITE) && addr_r[7];
              end
            end
          end
          ST_DONE: miso_r <= 1'b0;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign spi.miso_o = miso_r;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed bench for spi_reg_slave: bit-level SPI master plus a register-map model.
module tb_spi_reg_slave;

  localparam int unsigned NREGS = 8;
  localparam int unsigned SYNC  = 2;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] td0 = 8'h00;
  logic [7:0] td1 = 8'h00;

  spi_reg_slave_if spi();

  spi_reg_slave #(.NUM_REGS(NREGS), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rstn(rstn), .td0(td0), .td1(td1), .spi(spi)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] mregs [NREGS];
  logic [7:0] fcnt_m;
  logic       exp_miso;
  string      chk_name;
  event       chk_ev;
  logic [7:0] rx;

  initial begin
    forever begin
      @(chk_ev);
      total++;
      if (spi.miso_o !== exp_miso) begin
        bad++;
        $display("FAIL %s: miso=%b expected %b", chk_name, spi.miso_o, exp_miso);
      end
    end
  end

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] model_read(input logic [7:0] a);
    if (a >= 8'h80) return mregs[a % NREGS];
    case (a)
      8'h00:   return 8'hA5;
      8'h01:   return td0;
      8'h02:   return td1;
`ifdef SPI_FRAME_CNT_EN
      8'h7F:   return fcnt_m;
`endif
      default: return 8'h00;
    endcase
  endfunction

  // nbits < 24 aborts via csn; rst_at >= 0 pulls rstn before that bit; td_at >= 0 changes td0 before that bit.
  task automatic frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] d,
                       input int nbits, input int rst_at, input int td_at,
                       input logic [7:0] td_new, output logic [7:0] rxb);
    logic [23:0] f;
    logic [7:0]  eb;
    logic        aborted;
    f = {op, a, d};
    rxb = '0;
    eb = '0;
    aborted = 1'b0;
    @(negedge clk);
    spi.csn_i  = 1'b0;
    spi.sclk_i = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk8("rst_miso", {7'b0, spi.miso_o}, 8'h00);
        aborted = 1'b1;
        break;
      end
      if (i == 16) eb = (op == 8'h41) ? model_read(a) : 8'h00;
      if (i == td_at) td0 = td_new;
      spi.mosi_i = f[23-i];
      repeat (2) @(negedge clk);
      spi.sclk_i = 1'b1;
      repeat (2) @(negedge clk);
      exp_miso = (i < 16) ? 1'b0 : eb[23-i];
      chk_name = $sformatf("miso_bit%0d_op%02h_a%02h", i, op, a);
      -> chk_ev;
      if (i >= 16) rxb[23-i] = spi.miso_o;
      spi.sclk_i = 1'b0;
    end
    repeat (2) @(negedge clk);
    spi.csn_i  = 1'b1;
    spi.mosi_i = 1'b0;
    if (aborted) begin
      foreach (mregs[j]) mregs[j] = 8'h00;
      fcnt_m = 8'h00;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
    end else if (nbits == 24) begin
      if (op == 8'h40 && a[7]) mregs[a % NREGS] = d;
      if (op == 8'h40 || op == 8'h41) fcnt_m = fcnt_m + 8'd1;
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] rxb);
    frame(8'h41, a, 8'h00, 24, -1, -1, 8'h00, rxb);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] dummy;
    frame(8'h40, a, d, 24, -1, -1, 8'h00, dummy);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] dummy;
    spi.sclk_i = 1'b0;
    spi.csn_i  = 1'b1;
    spi.mosi_i = 1'b0;
    foreach (mregs[j]) mregs[j] = 8'h00;
    fcnt_m = 8'h00;
    repeat (4) @(negedge clk);
    chk8("reset_miso", {7'b0, spi.miso_o}, 8'h00);
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    td0 = 8'h81;
    td1 = 8'h3C;
    rd(8'h01, rx); chk8("t1_read_td0", rx, 8'h81);
    rd(8'h81, rx); chk8("t2_read_scratch_reset", rx, 8'h00);
    rd(8'h00, rx); chk8("read_id", rx, 8'hA5);
    rd(8'h02, rx); chk8("read_td1", rx, 8'h3C);
    rd(8'h10, rx); chk8("read_unmapped", rx, 8'h00);

    wr(8'h85, 8'hC5);
    rd(8'h85, rx); chk8("t3_read_85", rx, 8'hC5);
    rd(8'hC5, rx); chk8("t3_alias_C5", rx, 8'hC5);
    rd(8'h86, rx); chk8("t3_other_reg", rx, 8'h00);

    wr(8'hC5, 8'h81);
    rd(8'h85, rx); chk8("t4_alias_write", rx, 8'h81);
    td0 = 8'h5A;
    frame(8'h41, 8'h01, 8'h00, 24, -1, 20, 8'hA5, rx);
    chk8("t4_td0_snapshot", rx, 8'h5A);
    rd(8'h01, rx); chk8("t4_td0_new", rx, 8'hA5);

    frame(8'h42, 8'h85, 8'h77, 24, -1, -1, 8'h00, rx);
    chk8("bad_opcode_miso", rx, 8'h00);
    rd(8'h85, rx); chk8("bad_opcode_no_write", rx, 8'h81);

    frame(8'h40, 8'h83, 8'h55, 20, -1, -1, 8'h00, dummy);
    rd(8'h83, rx); chk8("t5_short_write", rx, 8'h00);
    wr(8'h83, 8'h55);
    rd(8'h83, rx); chk8("t5_full_write", rx, 8'h55);

    wr(8'h85, 8'hC5);
    frame(8'h41, 8'h85, 8'h00, 24, 18, -1, 8'h00, dummy);
    rd(8'h85, rx); chk8("t6_reset_clears_85", rx, 8'h00);
    rd(8'h83, rx); chk8("t6_reset_clears_83", rx, 8'h00);
    rd(8'h7F, rx);
`ifdef SPI_FRAME_CNT_EN
    chk8("t6_frame_count", rx, 8'h02);
`else
    chk8("t6_fcnt_absent", rx, 8'h00);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
